// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control sequencer: ALU control codes,
// MIPS opcode/funct values, operand-select and immediate-extend modes,
// the sequencer FSM state type and an immediate extension helper.
package alu_seq_pkg;

  // ALU control codes
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  // Operand A source: register rs or the shift amount field
  typedef enum logic {A_RS, A_SHAMT} a_sel_t;
  // Operand B source: register rt or the extended immediate
  typedef enum logic {B_RT, B_IMM} b_sel_t;
  // Immediate extension mode
  typedef enum logic {EXT_ZERO, EXT_SIGN} ext_t;

  // Sequencer FSM states
  typedef enum logic [2:0] {IDLE, DEC, EXE, WB, BR} state_t;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_t mode);
    return (mode == EXT_SIGN) ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Pure combinational instruction decoder for the ALU control sequencer.
// Ports:
//   inst      in  32  instruction word
//   aluc      out 4   ALU control code
//   a_sel     out     operand A source (rs or shamt)
//   b_sel     out     operand B source (rt or immediate)
//   ext       out     immediate extension mode
//   dest      out 5   destination register (rd for R-type, rt for I-type)
//   is_branch out 1   beq/bne
//   is_bne    out 1   branch sense is inverted (bne)
//   illegal   out 1   unsupported opcode or funct
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  aluc,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output ext_t        ext,
  output logic [4:0]  dest,
  output logic        is_branch,
  output logic        is_bne,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];

  // rs and shamt are consumed by the datapath, not by the decoder
  logic unused_fields;
  assign unused_fields = ^{inst[25:21], inst[10:6]};

  always_comb begin
    aluc      = ALUC_ADD;
    a_sel     = A_RS;
    b_sel     = B_RT;
    ext       = EXT_ZERO;
    dest      = 5'd0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest = rd;
        case (funct)
          FN_ADD: aluc = ALUC_ADD;
          FN_SUB: aluc = ALUC_SUB;
          FN_AND: aluc = ALUC_AND;
          FN_OR:  aluc = ALUC_OR;
          FN_XOR: aluc = ALUC_XOR;
          FN_SLL: begin aluc = ALUC_SLL; a_sel = A_SHAMT; end
          FN_SRL: begin aluc = ALUC_SRL; a_sel = A_SHAMT; end
          FN_SRA: begin aluc = ALUC_SRA; a_sel = A_SHAMT; end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin aluc = ALUC_ADD; b_sel = B_IMM; ext = EXT_SIGN; dest = rt; end
      OP_ANDI: begin aluc = ALUC_AND; b_sel = B_IMM; dest = rt; end
      OP_ORI:  begin aluc = ALUC_OR;  b_sel = B_IMM; dest = rt; end
      OP_XORI: begin aluc = ALUC_XOR; b_sel = B_IMM; dest = rt; end
      OP_LUI:  begin aluc = ALUC_LUI; b_sel = B_IMM; dest = rt; end
      OP_BEQ:  begin aluc = ALUC_SUB; is_branch = 1'b1; end
      OP_BNE:  begin aluc = ALUC_SUB; is_branch = 1'b1; is_bne = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU control sequencer. Accepts one instruction per handshake,
// reads operands from the register file, drives the external ALU, then
// issues a register write-back, a branch decision, or an illegal strobe.
// Ports:
//   clk, clrn            clock, synchronous active-low reset
//   inst_valid/inst      instruction offer; inst_ready high while idle
//   rs_addr/rt_addr      register-file read addresses (out)
//   rs_data/rt_data      register-file read data, combinational (in)
//   alu_a/alu_b/aluc     ALU operands and control (out)
//   alu_r/alu_z          ALU result and zero flag (in)
//   wb_valid/addr/data   write-back request held until wb_ready
//   br_valid/taken/off   one-cycle branch decision
//   err                  one-cycle illegal-instruction strobe
// All outputs are registered.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_z,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        br_valid,
  output logic        br_taken,
  output logic [31:0] br_off,
  output logic        err
);

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] inst_reg;

  logic [3:0]  dec_aluc;
  a_sel_t      dec_a_sel;
  b_sel_t      dec_b_sel;
  ext_t        dec_ext;
  logic [4:0]  dec_dest;
  logic        dec_is_branch;
  logic        dec_is_bne;
  logic        dec_illegal;

  // The latched instruction stays stable from DEC through WB/BR, so the
  // decoder output is valid in every state that consumes it.
  alu_seq_decode u_decode (
    .inst      (inst_reg),
    .aluc      (dec_aluc),
    .a_sel     (dec_a_sel),
    .b_sel     (dec_b_sel),
    .ext       (dec_ext),
    .dest      (dec_dest),
    .is_branch (dec_is_branch),
    .is_bne    (dec_is_bne),
    .illegal   (dec_illegal)
  );

  // inst_ready is registered and stays low for the first idle cycle after
  // reset, so acceptance keys off the registered flag.
  logic accept;
  assign accept = (state_reg == IDLE) && inst_ready && inst_valid;

  logic [31:0] a_next;
  logic [31:0] b_next;
  assign a_next = (dec_a_sel == A_SHAMT) ? {27'b0, inst_reg[10:6]} : rs_data;
  assign b_next = (dec_b_sel == B_IMM) ? extend_imm(inst_reg[15:0], dec_ext) : rt_data;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) state_next = DEC;
      DEC:  state_next = dec_illegal ? IDLE : EXE;
      EXE: begin
        if (dec_is_branch)       state_next = BR;
        else if (dec_dest != '0) state_next = WB;
        else                     state_next = IDLE;
      end
      WB:   if (wb_ready) state_next = IDLE;
      BR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_reg  <= IDLE;
      inst_reg   <= '0;
      inst_ready <= 1'b0;
      rs_addr    <= '0;
      rt_addr    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      aluc       <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      br_valid   <= 1'b0;
      br_taken   <= 1'b0;
      br_off     <= '0;
      err        <= 1'b0;
    end else begin
      state_reg  <= state_next;
      // Status strobes are derived from the upcoming state so that they are
      // registered yet aligned with the state they describe.
      inst_ready <= (state_next == IDLE);
      wb_valid   <= (state_next == WB);
      br_valid   <= (state_next == BR);
      err        <= (state_reg == DEC) && dec_illegal;

      if (accept) begin
        inst_reg <= inst;
        // Addresses go out during DEC so the zero-wait read returns data
        // in time to be registered at the end of DEC.
        rs_addr  <= inst[25:21];
        rt_addr  <= inst[20:16];
      end

      if ((state_reg == DEC) && !dec_illegal) begin
        aluc  <= dec_aluc;
        alu_a <= a_next;
        alu_b <= b_next;
      end

      if ((state_reg == EXE) && (state_next == WB)) begin
        wb_addr <= dec_dest;
        wb_data <= alu_r;
      end

      if ((state_reg == EXE) && (state_next == BR)) begin
        br_taken <= dec_is_bne ^ alu_z;
        br_off   <= {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  logic        clk;
  logic        clrn;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  aluc;
  logic [31:0] alu_r;
  logic        alu_z;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_off;
  logic        err;

  alu_seq_ctrl dut (
    .clk        (clk),
    .clrn       (clrn),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .aluc       (aluc),
    .alu_r      (alu_r),
    .alu_z      (alu_z),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_off     (br_off),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file (static contents) and ALU, both combinational
  logic [31:0] rf [32];
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  always_comb begin
    alu_r = 32'h0;
    case (aluc)
      4'h0: alu_r = alu_a + alu_b;
      4'h4: alu_r = alu_a - alu_b;
      4'h1: alu_r = alu_a & alu_b;
      4'h5: alu_r = alu_a | alu_b;
      4'h2: alu_r = alu_a ^ alu_b;
      4'h6: alu_r = {alu_b[15:0], 16'h0};
      4'h3: alu_r = alu_b << alu_a[4:0];
      4'h7: alu_r = alu_b >> alu_a[4:0];
      4'hF: alu_r = 32'($signed(alu_b) >>> alu_a[4:0]);
      default: alu_r = 32'h0;
    endcase
  end
  assign alu_z = (alu_r == 32'h0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Instruction-level reference: what the ALU must be asked and what must come back
  typedef struct packed {
    logic        illegal;
    logic        branch;
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  dest;
    logic        taken;
    logic [31:0] off;
  } rec_t;

  function automatic rec_t predict(input logic [31:0] w);
    rec_t r;
    logic [31:0] rs, rt, se, ze;
    logic [4:0]  sh;
    r  = '0;
    rs = rf[w[25:21]];
    rt = rf[w[20:16]];
    sh = w[10:6];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    r.a = rs;
    r.b = rt;
    r.dest = w[15:11];
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h20: begin r.aluc = 4'h0; r.res = rs + rt; end
          6'h22: begin r.aluc = 4'h4; r.res = rs - rt; end
          6'h24: begin r.aluc = 4'h1; r.res = rs & rt; end
          6'h25: begin r.aluc = 4'h5; r.res = rs | rt; end
          6'h26: begin r.aluc = 4'h2; r.res = rs ^ rt; end
          6'h00: begin r.aluc = 4'h3; r.a = {27'h0, sh}; r.res = rt << sh; end
          6'h02: begin r.aluc = 4'h7; r.a = {27'h0, sh}; r.res = rt >> sh; end
          6'h03: begin r.aluc = 4'hF; r.a = {27'h0, sh}; r.res = 32'($signed(rt) >>> sh); end
          default: r.illegal = 1'b1;
        endcase
      end
      6'h08: begin r.aluc = 4'h0; r.b = se; r.res = rs + se; r.dest = w[20:16]; end
      6'h0C: begin r.aluc = 4'h1; r.b = ze; r.res = rs & ze; r.dest = w[20:16]; end
      6'h0D: begin r.aluc = 4'h5; r.b = ze; r.res = rs | ze; r.dest = w[20:16]; end
      6'h0E: begin r.aluc = 4'h2; r.b = ze; r.res = rs ^ ze; r.dest = w[20:16]; end
      6'h0F: begin r.aluc = 4'h6; r.b = ze; r.res = {w[15:0], 16'h0}; r.dest = w[20:16]; end
      6'h04: begin r.aluc = 4'h4; r.branch = 1'b1; r.taken = (rs == rt); r.off = se << 2; end
      6'h05: begin r.aluc = 4'h4; r.branch = 1'b1; r.taken = (rs != rt); r.off = se << 2; end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  // Timeline expectations for the current cycle, refreshed at each rising edge:
  // accepted at edge 0, operands in cycle 2, err in cycle 2, wb/br from cycle 3.
  bit   started = 1'b0;
  bit   busy    = 1'b0;
  int   age     = 0;
  rec_t cur     = '0;
  bit   e_ready = 1'b0;
  bit   e_err   = 1'b0;
  bit   e_br    = 1'b0;
  bit   e_wb    = 1'b0;
  bit   e_ops   = 1'b0;
  bit   e_rst   = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      started = 1'b1;
      e_err = 1'b0; e_br = 1'b0; e_ops = 1'b0; e_rst = 1'b0;
      if (!clrn) begin
        e_rst = 1'b1; busy = 1'b0; e_wb = 1'b0; e_ready = 1'b0;
      end else if (!busy) begin
        if (e_ready && inst_valid) begin
          cur = predict(inst); busy = 1'b1; age = 1; e_ready = 1'b0;
        end else begin
          e_ready = 1'b1;
        end
      end else if (e_wb) begin
        if (wb_ready) begin e_wb = 1'b0; busy = 1'b0; e_ready = 1'b1; end
      end else begin
        age++;
        if (age == 2) begin
          if (cur.illegal) begin e_err = 1'b1; busy = 1'b0; e_ready = 1'b1; end
          else e_ops = 1'b1;
        end else if (age == 3) begin
          if (cur.branch) e_br = 1'b1;
          else if (cur.dest != 5'd0) e_wb = 1'b1;
          else begin busy = 1'b0; e_ready = 1'b1; end
        end else begin
          busy = 1'b0; e_ready = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the timeline model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("inst_ready", 32'(inst_ready), 32'(e_ready));
        chk("err", 32'(err), 32'(e_err));
        chk("wb_valid", 32'(wb_valid), 32'(e_wb));
        chk("br_valid", 32'(br_valid), 32'(e_br));
        if (e_rst)
          chk("reset_outputs_zero",
              32'(|{inst_ready, rs_addr, rt_addr, alu_a, alu_b, aluc, wb_valid, wb_addr,
                    wb_data, br_valid, br_taken, br_off, err}), 32'h0);
        if (e_ops) begin
          chk("aluc", 32'(aluc), 32'(cur.aluc));
          chk("alu_a", alu_a, cur.a);
          chk("alu_b", alu_b, cur.b);
        end
        if (e_wb) begin
          chk("wb_addr", 32'(wb_addr), 32'(cur.dest));
          chk("wb_data", wb_data, cur.res);
        end
        if (e_br) begin
          chk("br_taken", 32'(br_taken), 32'(cur.taken));
          chk("br_off", br_off, cur.off);
        end
      end
    end
  end

  // Transaction monitor: one line per completed transaction
  int          obs_wb_cnt  = 0;
  int          obs_br_cnt  = 0;
  int          obs_err_cnt = 0;
  logic [4:0]  obs_wb_addr = '0;
  logic [31:0] obs_wb_data = '0;
  logic        obs_taken   = 1'b0;
  logic [31:0] obs_off     = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid && wb_ready) begin
        obs_wb_cnt++; obs_wb_addr = wb_addr; obs_wb_data = wb_data;
        $display("wb   addr=%0d data=%h", wb_addr, wb_data);
      end
      if (br_valid) begin
        obs_br_cnt++; obs_taken = br_taken; obs_off = br_off;
        $display("br   taken=%0b off=%h", br_taken, br_off);
      end
      if (err) begin
        obs_err_cnt++;
        $display("err  illegal instruction");
      end
    end
  end

  // Captures taken by issue(): operands in cycle 2, strobes in cycles 2/3
  logic [3:0]  cap_aluc;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic        cap_err;
  logic        cap_wbv;
  logic        cap_brv;

  // Offer w, wait for acceptance, return in the middle of cycle 3
  task automatic issue(input logic [31:0] w);
    int n;
    $display("issue inst=%h", w);
    @(posedge clk); #1;
    inst = w; inst_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!inst_ready && n < 50);
    if (!inst_ready) timeout("accept");
    @(posedge clk); #1;
    inst_valid = 1'b0; inst = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    cap_aluc = aluc; cap_a = alu_a; cap_b = alu_b; cap_err = err;
    @(negedge clk);
    cap_wbv = wb_valid; cap_brv = br_valid;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!inst_ready && n < 50);
    if (!inst_ready) timeout("idle");
  endtask

  int wb0;
  int err0;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i * 3);
    rf[0] = 32'h0;
    rf[1] = 32'd5;
    rf[3] = 32'h8000_0000;
    rf[4] = 32'd7;
    rf[5] = 32'd7;
    clrn = 1'b0; inst_valid = 1'b0; inst = '0; wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    chk("ready_low_first_cycle", 32'(inst_ready), 32'h0);
    @(negedge clk);
    chk("ready_after_reset", 32'(inst_ready), 32'h1);

    // addi $2,$1,3
    issue(32'h2022_0003);
    chk("addi_aluc", 32'(cap_aluc), 32'h0);
    chk("addi_a", cap_a, 32'd5);
    chk("addi_b", cap_b, 32'd3);
    chk("addi_wbv_cycle3", 32'(cap_wbv), 32'h1);
    wait_idle();
    chk("addi_wb_addr", 32'(obs_wb_addr), 32'd2);
    chk("addi_wb_data", obs_wb_data, 32'd8);

    // sra $6,$3,4 / sll $7,$3,4 / srl $8,$3,4
    issue(32'h0003_3103);
    chk("sra_aluc", 32'(cap_aluc), 32'hF);
    chk("sra_a", cap_a, 32'd4);
    wait_idle();
    chk("sra_wb_data", obs_wb_data, 32'hF800_0000);
    issue(32'h0003_3900);
    chk("sll_aluc", 32'(cap_aluc), 32'h3);
    wait_idle();
    chk("sll_wb_data", obs_wb_data, 32'h0);
    issue(32'h0003_4102);
    chk("srl_aluc", 32'(cap_aluc), 32'h7);
    wait_idle();
    chk("srl_wb_data", obs_wb_data, 32'h0800_0000);

    // Other ALU ops: sub, xor, or, andi (zero-ext), ori, lui
    issue(32'h0081_7022); wait_idle(); chk("sub_wb_data", obs_wb_data, 32'd2);
    issue(32'h0024_8026); wait_idle(); chk("xor_wb_data", obs_wb_data, 32'd2);
    issue(32'h0024_8825); wait_idle(); chk("or_wb_data", obs_wb_data, 32'd7);
    issue(32'h306B_8001); chk("andi_b", cap_b, 32'h0000_8001);
    wait_idle(); chk("andi_wb_data", obs_wb_data, 32'h0);
    issue(32'h342C_8000); wait_idle(); chk("ori_wb_data", obs_wb_data, 32'h0000_8005);
    issue(32'h3C0D_1234); chk("lui_aluc", 32'(cap_aluc), 32'h6);
    wait_idle(); chk("lui_wb_data", obs_wb_data, 32'h1234_0000);

    // Branches
    wb0 = obs_wb_cnt;
    issue(32'h1085_FFFF);
    chk("beq_aluc", 32'(cap_aluc), 32'h4);
    chk("beq_brv_cycle3", 32'(cap_brv), 32'h1);
    @(negedge clk);
    chk("beq_brv_one_cycle", 32'(br_valid), 32'h0);
    wait_idle();
    chk("beq_taken", 32'(obs_taken), 32'h1);
    chk("beq_off", obs_off, 32'hFFFF_FFFC);
    issue(32'h1485_FFFF); wait_idle();
    chk("bne_eq_taken", 32'(obs_taken), 32'h0);
    issue(32'h1424_0010); wait_idle();
    chk("bne_ne_taken", 32'(obs_taken), 32'h1);
    chk("bne_off", obs_off, 32'h0000_0040);
    chk("branch_no_wb", 32'(obs_wb_cnt - wb0), 32'h0);
    chk("branch_count", 32'(obs_br_cnt), 32'd3);

    // Backpressure: wb_ready low for 5 WB cycles, next inst offered meanwhile
    wb_ready = 1'b0;
    issue(32'h0024_4820);
    chk("bp_wbv_cycle3", 32'(cap_wbv), 32'h1);
    @(posedge clk); #1;
    inst = 32'h382A_FFFF; inst_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_wbv", 32'(wb_valid), 32'h1);
      chk("bp_hold_ready", 32'(inst_ready), 32'h0);
      chk("bp_hold_addr", 32'(wb_addr), 32'd9);
      chk("bp_hold_data", wb_data, 32'd12);
    end
    @(posedge clk); #1 wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(inst_ready), 32'h0);
    @(negedge clk);
    chk("bp_ready_after", 32'(inst_ready), 32'h1);
    @(posedge clk); #1;
    inst_valid = 1'b0; inst = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("bp_next_accepted", 32'(inst_ready), 32'h0);
    wait_idle();
    chk("xori_wb_addr", 32'(obs_wb_addr), 32'd10);
    chk("xori_wb_data", obs_wb_data, 32'h0000_FFFA);

    // Illegal funct, illegal opcode, then add with rd=0
    wb0 = obs_wb_cnt; err0 = obs_err_cnt;
    issue(32'h0024_483F);
    chk("illegal_err_cycle2", 32'(cap_err), 32'h1);
    wait_idle();
    issue(32'hFC00_0000);
    chk("illop_err_cycle2", 32'(cap_err), 32'h1);
    wait_idle();
    issue(32'h0024_0020);
    chk("rd0_no_wbv", 32'(cap_wbv), 32'h0);
    wait_idle();
    chk("illegal_no_wb", 32'(obs_wb_cnt - wb0), 32'h0);
    chk("illegal_err_count", 32'(obs_err_cnt - err0), 32'd2);

    // Reset during a pending write-back
    wb0 = obs_wb_cnt;
    wb_ready = 1'b0;
    issue(32'h342C_8000);
    chk("rst_wbv_before", 32'(cap_wbv), 32'h1);
    @(posedge clk); #1 clrn = 1'b0;
    @(posedge clk); #1 clrn = 1'b1;
    @(negedge clk);
    chk("rst_wbv_cleared", 32'(wb_valid), 32'h0);
    chk("rst_ready_low", 32'(inst_ready), 32'h0);
    @(negedge clk);
    chk("rst_ready_rise", 32'(inst_ready), 32'h1);
    wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_wb", 32'(obs_wb_cnt - wb0), 32'h0);

    // One more instruction to show recovery
    issue(32'h2022_0003); wait_idle();
    chk("recover_wb_data", obs_wb_data, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle control sequencer that drives the 32-bit ALU from the instruction side. It accepts one MIPS-style instruction per handshake, decodes it to the ALU's 4-bit control code, and fetches operands through external register-file read ports. It presents them to the ALU, captures result and zero flag, then issues either a register write-back or a branch decision. It sits between the instruction source and the register file, with the ALU hanging off it combinationally.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  rising-edge clock
- clrn  in  1  synchronous reset, active-low
- inst_valid  in  1  instruction offered
- inst  in  32  instruction word
- inst_ready  out  1  sequencer idle, accepts inst
- rs_addr, rt_addr  out  5 each  register-file read addresses
- rs_data, rt_data  in  32 each  register-file read data, combinational from addresses
- alu_a, alu_b  out  32 each  ALU operands
- aluc  out  4  ALU control
- alu_r  in  32  ALU result
- alu_z  in  1  ALU zero flag
- wb_valid  out  1  write-back request
- wb_addr  out  5  destination register
- wb_data  out  32  write-back value
- wb_ready  in  1  register file accepts write-back
- br_valid  out  1  one-cycle branch decision strobe
- br_taken  out  1  branch decision, valid with br_valid
- br_off  out  32  sign-extended imm16 shifted left 2, valid with br_valid
- err  out  1  one-cycle illegal-instruction strobe

## Operation
- ALU codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- R-type (op 000000) funct mapping: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 000000 sll, 000010 srl, 000011 sra. Destination is rd.
  - Non-shift R-type: a=rs_data, b=rt_data.
  - Shifts: a={27'b0,shamt}, b=rt_data.
- I-type opcodes, destination rt:
  - 001000 addi: b is sign-extended.
  - 001100 andi, 001101 ori, 001110 xori: b is zero-extended.
  - 001111 lui: b={16'b0,imm}, aluc LUI.
- Branches: 000100 beq and 000101 bne use SUB with a=rs_data, b=rt_data. br_taken=alu_z for beq and ~alu_z for bne.
- Any other opcode or funct is illegal: err pulses and no write-back or branch is issued.
- Destination register 0: the instruction executes, but wb_valid is not asserted.
- FSM states:
  - IDLE: inst_ready=1. On inst_valid, latch inst and go to DEC.
  - DEC: drive rs_addr/rt_addr, register decoded aluc, alu_a, alu_b. Go to EXE, or to IDLE with err=1 if illegal.
  - EXE: ALU settles. Latch alu_r/alu_z. Go to WB for an ALU op with nonzero destination, to BR for a branch, otherwise to IDLE.
  - WB: wb_valid=1 with stable wb_addr/wb_data until wb_ready is sampled high, then go to IDLE.
  - BR: br_valid=1 for exactly one cycle, then go to IDLE.
- Reset (clrn low at an edge): state to IDLE; every output is 0. This includes inst_ready, which rises the first cycle after clrn is sampled high. Reset aborts any in-flight instruction, including a pending WB, with no write-back.

## Timing
- Every output is registered.
- Accept handshake is at edge 0. DEC occupies cycle 1, EXE cycle 2. wb_valid or br_valid is first high in cycle 3; err is high in cycle 2.
- inst_ready drops the cycle after acceptance and rises the cycle after WB completes, or after BR or err.
- Peak throughput is one instruction per 4 cycles. wb_ready backpressure extends WB indefinitely.
- rs_addr/rt_addr and rs_data/rt_data follow a zero-wait combinational read in the same cycle.
- inst is ignored when inst_ready=0.

## Structure
- Package alu_seq_pkg holds:
  - the aluc code constants
  - the opcode and funct constants
  - the FSM state enum: IDLE, DEC, EXE, WB, BR
- Sub-module alu_seq_decode is a pure combinational decoder. Input: inst. Outputs: aluc, operand-select, imm-extend mode, dest index, is_branch, is_bne, illegal.
- The top level holds the FSM and the datapath registers.

## Test plan
- addi: rs=1 holds 5, inst 0x20220003 (rt=2, imm 3) → aluc 0000, a=5, b=3, wb_valid in cycle 3 with wb_addr=2, wb_data=8.
- sra: rt holds 0x80000000, shamt 4 → aluc 1111, a=4, wb_data=0xF8000000. Also run sll and srl with the same operand to check the 0011 and 0111 codes.
- beq: equal operands, imm 0xFFFF → br_valid for one cycle with br_taken=1, br_off=0xFFFFFFFC. bne with equal operands → br_taken=0, no wb_valid.
- Backpressure: hold wb_ready=0 for 5 cycles → wb_valid, wb_addr and wb_data stay stable and inst_ready stays 0. Accepted one cycle after wb_ready rises.
- Illegal: funct 111111, then an add with rd=0 → err pulses in cycle 2 and neither instruction produces wb_valid.
- Reset: drop clrn during WB → all outputs 0 next cycle, no write-back. inst_ready=1 the cycle after clrn returns high.
